// File: rtl/btn_pkg.sv
// Shared constants for the button conditioner: repeat FSM encodings and
// default timing for a 10 MHz clock.
package btn_pkg;

  typedef logic [1:0] state_t;

  // Encoding 2'd3 is unused and treated as IDLE by the channel FSM.
  localparam state_t ST_IDLE   = 2'd0;
  localparam state_t ST_HOLD   = 2'd1;
  localparam state_t ST_REPEAT = 2'd2;

  localparam int DEBOUNCE_CYCLES = 512;
  localparam int REPEAT_DELAY    = 5_000_000;
  localparam int REPEAT_RATE     = 2_000_000;
  localparam int CNT_W           = 24;

endpackage

// File: rtl/btn_channel.sv
// One button channel: 2-flop synchronizer, stable-level debounce and a
// hold/auto-repeat FSM that emits single-cycle press and release pulses.
module btn_channel #(
  parameter int DEBOUNCE_CYCLES = btn_pkg::DEBOUNCE_CYCLES,
  parameter int REPEAT_DELAY    = btn_pkg::REPEAT_DELAY,
  parameter int REPEAT_RATE     = btn_pkg::REPEAT_RATE,
  parameter int CNT_W           = btn_pkg::CNT_W
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_raw,
  input  logic ena,
  input  logic repeat_en,
  output logic held,
  output logic press_pulse,
  output logic release_pulse
);
  import btn_pkg::*;

  localparam int DB_W = $clog2(DEBOUNCE_CYCLES);

  logic             sync_meta;
  logic             sync_q;
  logic             stable;
  logic             stable_next;
  logic [DB_W-1:0]  db_cnt;
  logic [DB_W-1:0]  db_cnt_next;
  logic             rise;
  logic             fall;
  state_t           state;
  state_t           state_next;
  logic [CNT_W-1:0] rep_cnt;
  logic [CNT_W-1:0] rep_cnt_next;
  logic             delay_done;
  logic             rate_done;
  logic             press_next;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_meta <= 1'b0;
      sync_q    <= 1'b0;
      stable    <= 1'b0;
      db_cnt    <= '0;
    end else begin
      sync_meta <= btn_raw;
      sync_q    <= sync_meta;
      stable    <= stable_next;
      db_cnt    <= db_cnt_next;
    end
  end

  // A new level is accepted only after DEBOUNCE_CYCLES consecutive
  // disagreeing samples; any agreeing sample restarts the count.
  always_comb begin
    stable_next = stable;
    db_cnt_next = '0;
    if (sync_q != stable) begin
      if (db_cnt == DB_W'(DEBOUNCE_CYCLES - 1)) begin
        stable_next = sync_q;
      end else begin
        db_cnt_next = db_cnt + 1'b1;
      end
    end
  end

  assign rise       = stable_next & ~stable;
  assign fall       = ~stable_next & stable;
  assign delay_done = (rep_cnt == CNT_W'(REPEAT_DELAY - 1));
  assign rate_done  = (rep_cnt == CNT_W'(REPEAT_RATE - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= ST_IDLE;
      rep_cnt <= '0;
    end else begin
      state   <= state_next;
      rep_cnt <= rep_cnt_next;
    end
  end

  always_comb begin
    state_next   = state;
    rep_cnt_next = rep_cnt;
    if (!ena || fall) begin
      state_next   = ST_IDLE;
      rep_cnt_next = '0;
    end else begin
      case (state)
        ST_HOLD: begin
          if (!repeat_en) begin
            rep_cnt_next = '0;
          end else if (delay_done) begin
            state_next   = ST_REPEAT;
            rep_cnt_next = '0;
          end else begin
            rep_cnt_next = rep_cnt + 1'b1;
          end
        end
        ST_REPEAT: begin
          if (!repeat_en) begin
            state_next   = ST_HOLD;
            rep_cnt_next = '0;
          end else if (rate_done) begin
            rep_cnt_next = '0;
          end else begin
            rep_cnt_next = rep_cnt + 1'b1;
          end
        end
        default: begin
          // IDLE is left only on a fresh accepted press, never on ena rising.
          state_next   = rise ? ST_HOLD : ST_IDLE;
          rep_cnt_next = '0;
        end
      endcase
    end
  end

  always_comb begin
    press_next = 1'b0;
    if (ena && !fall) begin
      case (state)
        ST_HOLD:   press_next = repeat_en & delay_done;
        ST_REPEAT: press_next = repeat_en & rate_done;
        default:   press_next = rise;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
    end else begin
      press_pulse   <= press_next;
      release_pulse <= fall;
    end
  end

  assign held = stable;

endmodule

// File: rtl/btn_conditioner.sv
// Conditions N_BTN raw push buttons into debounced levels plus single-cycle
// press (with optional auto-repeat) and release pulses.
module btn_conditioner #(
  parameter int N_BTN           = 4,
  parameter int DEBOUNCE_CYCLES = btn_pkg::DEBOUNCE_CYCLES,
  parameter int REPEAT_DELAY    = btn_pkg::REPEAT_DELAY,
  parameter int REPEAT_RATE     = btn_pkg::REPEAT_RATE,
  parameter int CNT_W           = btn_pkg::CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_BTN-1:0] btn_raw,
  input  logic             ena,
  input  logic [N_BTN-1:0] repeat_en,
  output logic [N_BTN-1:0] held,
  output logic [N_BTN-1:0] press_pulse,
  output logic [N_BTN-1:0] release_pulse
);
  import btn_pkg::*;

  for (genvar i = 0; i < N_BTN; i++) begin : g_chan
    btn_channel #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .REPEAT_DELAY   (REPEAT_DELAY),
      .REPEAT_RATE    (REPEAT_RATE),
      .CNT_W          (CNT_W)
    ) u_chan (
      .clk          (clk),
      .reset        (reset),
      .btn_raw      (btn_raw[i]),
      .ena          (ena),
      .repeat_en    (repeat_en[i]),
      .held         (held[i]),
      .press_pulse  (press_pulse[i]),
      .release_pulse(release_pulse[i])
    );
  end

endmodule
